lsq_dcache: RTL and testbench
=============================

// Module: lsq_dcache
// PURPOSE
//  Blocking-miss, write-back, write-allocate data cache between the LSQ and the 64-bit tagged main memory.
//  2-way set-associative, 32 sets, 8-byte lines, true LRU per set; at most one outstanding memory fill.
//  Serves loads and stores from the LSQ; fills lines on a load miss and writes back dirty victims.
// PARAMETERS
//  NUM_SETS   32  sets; index = addr[7:3], tag = addr[31:8], byte offset addr[2:0] ignored
//  NUM_WAYS   2   ways per set (fixed); LRU is one bit per set
//  XLEN       32  address width
// PORTS
//  clock               in   1   system clock, posedge
//  reset               in   1   asynchronous, active-high
//  stall               in   1   freeze: no state update, no memory command, load/store valid outputs 0
//  Dmem2proc_response  in   4   memory tag for the request issued this cycle; 0 = rejected, retry
//  Dmem2proc_data      in   64  fill data, valid when Dmem2proc_tag matches the pending tag
//  Dmem2proc_tag       in   4   tag of completing load; 0 = none
//  lsq_load            in   pkt {valid, addr[31:0]}
//  lsq_store           in   pkt {valid, addr[31:0], value[63:0]}
//  dcache_load         out  pkt {valid (hit), value[63:0]}
//  dcache_store        out  pkt {valid (store committed to cache)}
//  proc2Dmem_command   out  2   0 NONE, 1 LOAD, 2 STORE
//  proc2Dmem_addr      out  32  line-aligned address (addr & ~7)
//  proc2Dmem_data      out  64  write-back data
// BEHAVIOUR
//  Reset: all valid, dirty, and LRU bits 0, no pending miss; all outputs 0, command NONE.
//  Load hit (lsq_load.valid, any way valid with tag match): combinational, same cycle.
//   Sets dcache_load.valid=1 and dcache_load.value=line; marks the hit way MRU at posedge.
//  Load miss: dcache_load.valid=0 and value=0.
//   If no miss is pending and the memory port is free, drive LOAD with the line address.
//   Nonzero Dmem2proc_response is latched at posedge as the pending tag; response 0 means reissue next cycle.
//   When Dmem2proc_tag equals the pending tag: write Dmem2proc_data into the LRU way, valid=1, dirty=0, way becomes MRU.
//   Clear the pending tag. The LSQ retries the load and hits.
//  Eviction: if the LRU victim is valid and dirty, first issue STORE of victim data to victim address.
//   Do not overwrite the victim until a nonzero response is seen.
//  Store hit: write the whole 64-bit line, dirty=1, way becomes MRU; dcache_store.valid=1 same cycle, update at posedge.
//  Store miss: allocate the LRU way with no fetch, because the store covers the full line.
//   Clean or invalid victim: write and commit in the same cycle, as for a hit.
//   Dirty victim: drive STORE writeback; commit (dcache_store.valid=1, line written) in the cycle the response is nonzero.
//   Otherwise valid=0 and the LSQ holds the request.
//  Port priority: victim writeback > new LOAD request; one command per cycle.
//   While a fill is pending, further load misses are not issued; hits are still served.
//  Simultaneous load and store valid: both are served if both hit; a store-miss writeback wins the port.
//  Fill arriving in the same cycle as a store to the same set: the fill goes to the recorded victim way, the store to the other way.
//  Reset mid-miss: the pending tag is dropped; a later response with that tag is ignored.
// TESTING
//  Store 16 val 107 -> store.valid=1, load.valid=0, command NONE; then load 16 -> valid=1, value=107.
//  Load 8 cold -> valid=0, LOAD addr 8; after mem latency the tag matches -> retry load 8 valid=1, value=mem[8].
//  Store 2832 val 1122 (same set as 16) -> both ways occupied; load 2832 -> 1122, load 16 -> 107.
//  Store 16 val 806 over dirty line -> hit, no memory traffic; load 16 -> 806.
//  Store 4112 val 1027 -> evicts LRU 2832 with STORE addr 2832 data 1122; load 2832 miss, load 4112 -> 1027.
//  Response 0 on LOAD -> reissued next cycle; stall=1 -> all valids 0, command NONE, state unchanged.

Source files
------------

// File: rtl/lsq_dcache_if.sv
// LSQ / main-memory bundle seen by the data cache.
// The cache side uses the slave modport; the LSQ and memory model use master.
interface lsq_dcache_if;
    logic        stall;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;

    logic        lsq_load_valid;
    logic [31:0] lsq_load_addr;
    logic        lsq_store_valid;
    logic [31:0] lsq_store_addr;
    logic [63:0] lsq_store_value;

    logic        dcache_load_valid;
    logic [63:0] dcache_load_value;
    logic        dcache_store_valid;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;

    modport slave (
        input  stall, Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  lsq_load_valid, lsq_load_addr,
        input  lsq_store_valid, lsq_store_addr, lsq_store_value,
        output dcache_load_valid, dcache_load_value, dcache_store_valid,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data
    );

    modport master (
        output stall, Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output lsq_load_valid, lsq_load_addr,
        output lsq_store_valid, lsq_store_addr, lsq_store_value,
        input  dcache_load_valid, dcache_load_value, dcache_store_valid,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data
    );
endinterface

// File: rtl/lsq_dcache.sv
// Blocking-miss, write-back, write-allocate 2-way data cache with one outstanding fill.
// Lookups are combinational; all state changes land on the rising clock edge.
module lsq_dcache #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 32
) (
    input  logic        clock,
    input  logic        reset,
    lsq_dcache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = XLEN - IDX_W - 3;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_e;

    // Line storage: combinational read so hits are answered in the same cycle.
    logic [TAG_W-1:0] tag_mem  [NUM_SETS][NUM_WAYS];
    logic [63:0]      data_mem [NUM_SETS][NUM_WAYS];

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_q, dirty_d;
    logic [NUM_SETS-1:0]               lru_q, lru_d;   // index of the least-recently-used way

    state_e           state_q, state_d;
    logic [3:0]       pend_tag_q, pend_tag_d;
    logic [IDX_W-1:0] pend_set_q, pend_set_d;
    logic             pend_way_q, pend_way_d;
    logic [TAG_W-1:0] pend_line_tag_q, pend_line_tag_d;

    logic [IDX_W-1:0] ld_idx, st_idx;
    logic [TAG_W-1:0] ld_tag, st_tag;
    logic [NUM_WAYS-1:0] ld_hit_vec, st_hit_vec;

    logic active;
    logic ld_hit, ld_hit_way, ld_victim, ld_victim_dirty, ld_can_req;
    logic st_hit, st_hit_way, st_way, st_victim_dirty, pend_same_set;
    logic st_wb, ld_wb, ld_req, st_block, st_commit;
    logic resp_ok, fill_now;
    logic unused_addr_bits;

    assign ld_idx = bus.lsq_load_addr[IDX_W+2:3];
    assign ld_tag = bus.lsq_load_addr[XLEN-1:IDX_W+3];
    assign st_idx = bus.lsq_store_addr[IDX_W+2:3];
    assign st_tag = bus.lsq_store_addr[XLEN-1:IDX_W+3];
    assign unused_addr_bits = ^{bus.lsq_load_addr[2:0], bus.lsq_store_addr[2:0]};

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign ld_hit_vec[gi] = valid_q[ld_idx][gi] && (tag_mem[ld_idx][gi] == ld_tag);
        assign st_hit_vec[gi] = valid_q[st_idx][gi] && (tag_mem[st_idx][gi] == st_tag);
    end

    always_comb begin
        active     = !bus.stall && !reset;
        resp_ok    = (bus.Dmem2proc_response != 4'd0);

        ld_hit          = bus.lsq_load_valid && (|ld_hit_vec);
        ld_hit_way      = ld_hit_vec[1];
        ld_victim       = lru_q[ld_idx];
        ld_victim_dirty = valid_q[ld_idx][ld_victim] && dirty_q[ld_idx][ld_victim];
        ld_can_req      = bus.lsq_load_valid && !ld_hit && (state_q == S_IDLE);

        st_hit        = bus.lsq_store_valid && (|st_hit_vec);
        st_hit_way    = st_hit_vec[1];
        pend_same_set = (state_q == S_FILL) && (st_idx == pend_set_q);
        // A store miss never allocates into the way reserved for the outstanding fill.
        if (st_hit)
            st_way = st_hit_way;
        else if (pend_same_set)
            st_way = ~pend_way_q;
        else
            st_way = lru_q[st_idx];
        st_victim_dirty = !st_hit && valid_q[st_idx][st_way] && dirty_q[st_idx][st_way];

        // One command per cycle: store writeback, then load-victim writeback, then fetch.
        st_wb  = active && bus.lsq_store_valid && st_victim_dirty;
        ld_wb  = active && ld_can_req && ld_victim_dirty && !st_wb;
        ld_req = active && ld_can_req && !ld_victim_dirty && !st_wb;

        // Hold a store that would touch a way being cleaned or refilled for a load.
        st_block = (pend_same_set && (st_way == pend_way_q))
                || ((ld_wb || ld_req) && (st_idx == ld_idx) && (st_way == ld_victim));
        st_commit = active && bus.lsq_store_valid && !st_block && (!st_victim_dirty || resp_ok);

        fill_now = active && (state_q == S_FILL) && (bus.Dmem2proc_tag != 4'd0)
                && (bus.Dmem2proc_tag == pend_tag_q);
    end

    always_comb begin
        bus.dcache_load_valid  = active && ld_hit;
        bus.dcache_load_value  = (active && ld_hit) ? data_mem[ld_idx][ld_hit_way] : 64'd0;
        bus.dcache_store_valid = st_commit;
        bus.proc2Dmem_command  = CMD_NONE;
        bus.proc2Dmem_addr     = 32'd0;
        bus.proc2Dmem_data     = 64'd0;
        if (st_wb) begin
            bus.proc2Dmem_command = CMD_STORE;
            bus.proc2Dmem_addr    = {tag_mem[st_idx][st_way], st_idx, 3'b000};
            bus.proc2Dmem_data    = data_mem[st_idx][st_way];
        end else if (ld_wb) begin
            bus.proc2Dmem_command = CMD_STORE;
            bus.proc2Dmem_addr    = {tag_mem[ld_idx][ld_victim], ld_idx, 3'b000};
            bus.proc2Dmem_data    = data_mem[ld_idx][ld_victim];
        end else if (ld_req) begin
            bus.proc2Dmem_command = CMD_LOAD;
            bus.proc2Dmem_addr    = {bus.lsq_load_addr[XLEN-1:3], 3'b000};
        end
    end

    // Next-state: later updates to the same set take precedence for LRU.
    always_comb begin
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        lru_d           = lru_q;
        state_d         = state_q;
        pend_tag_d      = pend_tag_q;
        pend_set_d      = pend_set_q;
        pend_way_d      = pend_way_q;
        pend_line_tag_d = pend_line_tag_q;

        if (active && ld_hit)
            lru_d[ld_idx] = ~ld_hit_way;

        if (ld_wb && resp_ok)
            dirty_d[ld_idx][ld_victim] = 1'b0;

        if (ld_req && resp_ok) begin
            state_d         = S_FILL;
            pend_tag_d      = bus.Dmem2proc_response;
            pend_set_d      = ld_idx;
            pend_way_d      = ld_victim;
            pend_line_tag_d = ld_tag;
        end

        if (fill_now) begin
            valid_d[pend_set_q][pend_way_q] = 1'b1;
            dirty_d[pend_set_q][pend_way_q] = 1'b0;
            lru_d[pend_set_q]               = ~pend_way_q;
            state_d                         = S_IDLE;
        end

        if (st_commit) begin
            valid_d[st_idx][st_way] = 1'b1;
            dirty_d[st_idx][st_way] = 1'b1;
            lru_d[st_idx]           = ~st_way;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q         <= '0;
            dirty_q         <= '0;
            lru_q           <= '0;
            state_q         <= S_IDLE;
            pend_tag_q      <= 4'd0;
            pend_set_q      <= '0;
            pend_way_q      <= 1'b0;
            pend_line_tag_q <= '0;
        end else begin
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            lru_q           <= lru_d;
            state_q         <= state_d;
            pend_tag_q      <= pend_tag_d;
            pend_set_q      <= pend_set_d;
            pend_way_q      <= pend_way_d;
            pend_line_tag_q <= pend_line_tag_d;
        end
    end

    // Tag/data contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clock) begin
        if (fill_now) begin
            data_mem[pend_set_q][pend_way_q] <= bus.Dmem2proc_data;
            tag_mem[pend_set_q][pend_way_q]  <= pend_line_tag_q;
        end
        if (st_commit) begin
            data_mem[st_idx][st_way] <= bus.lsq_store_value;
            tag_mem[st_idx][st_way]  <= st_tag;
        end
    end
endmodule

// File: tb/tb_lsq_dcache.sv
// Directed scoreboard bench for lsq_dcache with a tagged memory model (fixed fill latency).
module tb_lsq_dcache;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    lsq_dcache_if bus ();

    lsq_dcache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic        ld_v;
        logic [63:0] ld_val;
        logic        st_v;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        bit          chk_val;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } fill_t;
    fill_t       fill_q[$];
    logic [63:0] mem [logic [31:0]];
    logic [3:0]  next_tag = 4'd1;
    int          reject_cnt = 0;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {32'hD000_0000, a};
    endfunction

    initial begin
        bus.Dmem2proc_response = 4'd0;
        bus.Dmem2proc_tag      = 4'd0;
        bus.Dmem2proc_data     = 64'd0;
        forever begin
            @(negedge clock);
            #1;
            bus.Dmem2proc_response = 4'd0;
            bus.Dmem2proc_tag      = 4'd0;
            bus.Dmem2proc_data     = 64'd0;
            if (fill_q.size() > 0 && fill_q[0].due <= cyc) begin
                fill_t f;
                f = fill_q.pop_front();
                bus.Dmem2proc_tag  = f.tag;
                bus.Dmem2proc_data = f.data;
            end
            if (bus.proc2Dmem_command == 2'd1) begin
                if (reject_cnt > 0) begin
                    reject_cnt--;
                end else begin
                    bus.Dmem2proc_response = next_tag;
                    fill_q.push_back('{due: cyc + 3, tag: next_tag, data: mem_rd(bus.proc2Dmem_addr)});
                    next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
                end
            end else if (bus.proc2Dmem_command == 2'd2) begin
                bus.Dmem2proc_response = next_tag;
                mem[bus.proc2Dmem_addr] = bus.proc2Dmem_data;
                next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input string name,
                       input bit lv, input logic [31:0] la,
                       input bit sv, input logic [31:0] sa, input logic [63:0] sval,
                       input bit stl,
                       input bit e_lv, input logic [63:0] e_lval, input bit e_sv,
                       input logic [1:0] e_cmd, input logic [31:0] e_addr, input logic [63:0] e_data);
        @(negedge clock);
        bus.lsq_load_valid  = lv;
        bus.lsq_load_addr   = la;
        bus.lsq_store_valid = sv;
        bus.lsq_store_addr  = sa;
        bus.lsq_store_value = sval;
        bus.stall           = stl;
        exp_q.push_back('{cyc: cyc, name: name, ld_v: e_lv, ld_val: e_lval, st_v: e_sv,
                          cmd: e_cmd, addr: e_addr, data: e_data, chk_val: !stl});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.lsq_load_valid  = 1'b0;
            bus.lsq_store_valid = 1'b0;
            bus.stall           = 1'b0;
        end
    endtask

    localparam logic [63:0] MEM8  = 64'hD000_0000_0000_0008;
    localparam logic [63:0] MEM40 = 64'hD000_0000_0000_0028;
    localparam logic [63:0] MEM48 = 64'hD000_0000_0000_0030;
    localparam logic [63:0] MEM56 = 64'hD000_0000_0000_0038;

    initial begin
        bus.stall = 1'b0;
        bus.lsq_load_valid = 1'b0;  bus.lsq_load_addr = 32'd0;
        bus.lsq_store_valid = 1'b0; bus.lsq_store_addr = 32'd0; bus.lsq_store_value = 64'd0;

        //   name            lv la    sv sa    sval  stl  e_lv e_lval e_sv cmd addr  data
        txn("in_reset",      0, 0,    0, 0,    0,    0,   0, 0,     0,   0,  0,    0);
        @(negedge clock); reset = 1'b0;
        txn("reset_idle",    0, 0,    0, 0,    0,    0,   0, 0,     0,   0,  0,    0);
        txn("st16_107",      0, 0,    1, 16,   107,  0,   0, 0,     1,   0,  0,    0);
        txn("ld16",          1, 16,   0, 0,    0,    0,   1, 107,   0,   0,  0,    0);
        txn("ld8_miss",      1, 8,    0, 0,    0,    0,   0, 0,     0,   1,  8,    0);
        idle(4);
        txn("ld8_hit",       1, 8,    0, 0,    0,    0,   1, MEM8,  0,   0,  0,    0);
        txn("st2832_1122",   0, 0,    1, 2832, 1122, 0,   0, 0,     1,   0,  0,    0);
        txn("ld2832",        1, 2832, 0, 0,    0,    0,   1, 1122,  0,   0,  0,    0);
        txn("ld16_b",        1, 16,   0, 0,    0,    0,   1, 107,   0,   0,  0,    0);
        txn("st16_806",      0, 0,    1, 16,   806,  0,   0, 0,     1,   0,  0,    0);
        txn("ld16_806",      1, 16,   0, 0,    0,    0,   1, 806,   0,   0,  0,    0);
        txn("st4112_evict",  0, 0,    1, 4112, 1027, 0,   0, 0,     1,   2,  2832, 1122);
        txn("ld2832_wb16",   1, 2832, 0, 0,    0,    0,   0, 0,     0,   2,  16,   806);
        txn("ld2832_fetch",  1, 2832, 0, 0,    0,    0,   0, 0,     0,   1,  2832, 0);
        idle(4);
        txn("ld2832_refill", 1, 2832, 0, 0,    0,    0,   1, 1122,  0,   0,  0,    0);
        txn("ld4112",        1, 4112, 0, 0,    0,    0,   1, 1027,  0,   0,  0,    0);
        reject_cnt = 1;
        txn("ld40_reject",   1, 40,   0, 0,    0,    0,   0, 0,     0,   1,  40,   0);
        txn("ld40_reissue",  1, 40,   0, 0,    0,    0,   0, 0,     0,   1,  40,   0);
        idle(4);
        txn("ld40_hit",      1, 40,   0, 0,    0,    0,   1, MEM40, 0,   0,  0,    0);
        txn("stall_hit",     1, 4112, 1, 4112, 999,  1,   0, 0,     0,   0,  0,    0);
        txn("stall_miss",    1, 56,   0, 0,    0,    1,   0, 0,     0,   0,  0,    0);
        txn("unstall_ld4112",1, 4112, 0, 0,    0,    0,   1, 1027,  0,   0,  0,    0);
        txn("dual_hit",      1, 4112, 1, 40,   55,   0,   1, 1027,  1,   0,  0,    0);
        txn("ld40_55",       1, 40,   0, 0,    0,    0,   1, 55,    0,   0,  0,    0);
        txn("st2832_1500",   0, 0,    1, 2832, 1500, 0,   0, 0,     1,   0,  0,    0);
        txn("ld4112_c",      1, 4112, 0, 0,    0,    0,   1, 1027,  0,   0,  0,    0);
        txn("stwb_wins",     1, 56,   1, 16,   77,   0,   0, 0,     1,   2,  2832, 1500);
        txn("ld56_fetch",    1, 56,   0, 0,    0,    0,   0, 0,     0,   1,  56,   0);
        idle(4);
        txn("ld56_hit",      1, 56,   0, 0,    0,    0,   1, MEM56, 0,   0,  0,    0);
        txn("ld16_77",       1, 16,   0, 0,    0,    0,   1, 77,    0,   0,  0,    0);
        txn("ld2832_wb4112", 1, 2832, 0, 0,    0,    0,   0, 0,     0,   2,  4112, 1027);
        txn("ld2832_fetch2", 1, 2832, 0, 0,    0,    0,   0, 0,     0,   1,  2832, 0);
        idle(2);
        txn("st4368_fillcyc",0, 0,    1, 4368, 9,    0,   0, 0,     1,   2,  16,   77);
        idle(1);
        txn("ld2832_1500",   1, 2832, 0, 0,    0,    0,   1, 1500,  0,   0,  0,    0);
        txn("ld4368_9",      1, 4368, 0, 0,    0,    0,   1, 9,     0,   0,  0,    0);
        txn("ld48_fetch",    1, 48,   0, 0,    0,    0,   0, 0,     0,   1,  48,   0);
        @(negedge clock);
        bus.lsq_load_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        txn("ld48_after_rst",1, 48,   0, 0,    0,    0,   0, 0,     0,   1,  48,   0);
        idle(4);
        txn("ld48_hit",      1, 48,   0, 0,    0,    0,   1, MEM48, 0,   0,  0,    0);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string tname, input string fld, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tname, fld, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %-15s ld_v=%0b ld_val=%0d st_v=%0b cmd=%0d addr=%0d data=%0d",
                         e.name, bus.dcache_load_valid, bus.dcache_load_value,
                         bus.dcache_store_valid, bus.proc2Dmem_command,
                         bus.proc2Dmem_addr, bus.proc2Dmem_data);
                chk(e.name, "load_valid",  {63'd0, bus.dcache_load_valid},  {63'd0, e.ld_v});
                chk(e.name, "store_valid", {63'd0, bus.dcache_store_valid}, {63'd0, e.st_v});
                chk(e.name, "command",     {62'd0, bus.proc2Dmem_command},  {62'd0, e.cmd});
                if (e.chk_val)
                    chk(e.name, "load_value", bus.dcache_load_value, e.ld_val);
                if (e.cmd != 2'd0)
                    chk(e.name, "mem_addr", {32'd0, bus.proc2Dmem_addr}, {32'd0, e.addr});
                if (e.cmd == 2'd2)
                    chk(e.name, "mem_data", bus.proc2Dmem_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
